// File: rtl/dm_load_unit.sv
// rtl/dm_load_unit.sv - load unit: aligns and extends one word read from synchronous data memory
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   req_valid_i/req_ready_o    load request handshake
//   req_addr_i, req_op_i       byte address and load type (0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU)
//   mem_rd_en_o, mem_rd_addr_o word read strobe and word address to memory
//   mem_rd_data_i              read word, one cycle after mem_rd_en_o
//   rsp_valid_o/rsp_ready_i    result handshake
//   rsp_data_o, rsp_exc_o      extended result, misaligned/invalid-op flag
module dm_load_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [2:0]        req_op_i,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-3:0] mem_rd_addr_o,
  input  logic [31:0]       mem_rd_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_data_o,
  output logic              rsp_exc_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_exc_q, rsp_exc_d;

  logic        legal;
  logic        accept;
  logic [15:0] half;
  logic [7:0]  byte_sel;
  logic [31:0] result;

  always_comb begin
    legal = 1'b0;
    case (req_op_i)
      OP_LW:          legal = (req_addr_i[1:0] == 2'b00);
      OP_LH, OP_LHU:  legal = ~req_addr_i[0];
      OP_LB, OP_LBU:  legal = 1'b1;
      default:        legal = 1'b0;
    endcase
  end

  // A response slot frees up in the same cycle the consumer takes it.
  assign req_ready_o   = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready_i);
  assign accept        = req_valid_i && req_ready_o;
  assign mem_rd_en_o   = accept && legal;
  assign mem_rd_addr_o = req_addr_i[ADDR_W-1:2];

  // Lane selection uses the offset latched at accept, not the live address.
  always_comb begin
    half     = off_q[1] ? mem_rd_data_i[31:16] : mem_rd_data_i[15:0];
    byte_sel = mem_rd_data_i[7:0];
    case (off_q)
      2'd0:    byte_sel = mem_rd_data_i[7:0];
      2'd1:    byte_sel = mem_rd_data_i[15:8];
      2'd2:    byte_sel = mem_rd_data_i[23:16];
      default: byte_sel = mem_rd_data_i[31:24];
    endcase
    case (op_q)
      OP_LW:   result = mem_rd_data_i;
      OP_LH:   result = {{16{half[15]}}, half};
      OP_LHU:  result = {16'h0000, half};
      OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  result = {24'h000000, byte_sel};
      default: result = 32'h0000_0000;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    off_d      = off_q;
    rsp_data_d = rsp_data_q;
    rsp_exc_d  = rsp_exc_q;
    case (state_q)
      S_WAIT: begin
        rsp_data_d = result;
        rsp_exc_d  = 1'b0;
        state_d    = S_RESP;
      end
      S_IDLE, S_RESP: begin
        if (state_q == S_RESP && rsp_ready_i) state_d = S_IDLE;
        if (accept) begin
          if (legal) begin
            op_d    = req_op_i;
            off_d   = req_addr_i[1:0];
            state_d = S_WAIT;
          end else begin
            // Illegal requests answer directly without touching memory.
            rsp_data_d = 32'h0000_0000;
            rsp_exc_d  = 1'b1;
            state_d    = S_RESP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      op_q       <= 3'd0;
      off_q      <= 2'd0;
      rsp_data_q <= 32'h0000_0000;
      rsp_exc_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      off_q      <= off_d;
      rsp_data_q <= rsp_data_d;
      rsp_exc_q  <= rsp_exc_d;
    end
  end

  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_exc_o   = rsp_exc_q;

endmodule
